// File: rtl/mux_pkg.sv
// Shared types and helpers for the N:1 streaming multiplexer.
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_e;

  // Wrap-around increment of a channel index in the range 0..n-1.
  function automatic int next_ptr(input int k, input int n);
    return (k == n - 1) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above ptr, wrapping.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_any
);

  localparam int SW = $clog2(N);

  logic [SW:0]   sum;
  logic [SW-1:0] cand;

  // ptr is always below N, so one conditional subtraction keeps the candidate in range.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int off = 0; off < N; off++) begin
      sum = {1'b0, ptr} + (SW + 1)'(off);
      if (sum >= (SW + 1)'(N)) sum = sum - (SW + 1)'(N);
      cand = sum[SW-1:0];
      if (!gnt_any && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
        gnt_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_n1_stream.sv
// N:1 valid/ready stream multiplexer, fixed-select or round-robin, with one output register.
module mux_n1_stream
  import mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [SW-1:0]  s,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  input  logic           out_ready
);

  localparam logic [SW:0] NCH = (SW + 1)'(N);

  mux_mode_e     mode_e;
  logic [SW-1:0] ptr;
  logic [N-1:0]  rr_gnt;
  logic [SW-1:0] rr_idx;
  logic          rr_any;
  logic [N-1:0]  fixed_gnt;
  logic [N-1:0]  sel_gnt;
  logic [SW-1:0] sel_idx;
  logic          sel_any;
  logic          load;
  logic          xfer;
  logic [W-1:0]  xfer_data;

  assign mode_e = mux_mode_e'(mode);

  rr_arbiter #(.N(N)) u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // Select values beyond the last channel (non-power-of-two N) grant nothing.
  always_comb begin
    fixed_gnt = '0;
    if ({1'b0, s} < NCH) fixed_gnt[s] = 1'b1;
  end

  always_comb begin
    if (mode_e == MODE_RR) begin
      sel_gnt = rr_gnt;
      sel_idx = rr_idx;
      sel_any = rr_any;
    end else begin
      sel_gnt = fixed_gnt;
      sel_idx = s;
      sel_any = |fixed_gnt;
    end
  end

  assign load     = !out_valid || out_ready;
  assign in_ready = rst ? '0 : (sel_gnt & {N{load}});
  assign xfer     = sel_any && |(in_ready & in_valid);

  always_comb begin
    xfer_data = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_gnt[i]) xfer_data = in_data[i*W +: W];
    end
  end

  // A load takes priority over a drain, so a same-cycle drain+load keeps out_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= xfer_data;
      out_ch    <= sel_idx;
      if (mode_e == MODE_RR) ptr <= SW'(next_ptr(int'(sel_idx), N));
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_n1_stream.sv
// Self-checking bench for mux_n1_stream: directed scenarios plus randomized traffic vs. a queue-free model.
module tb_mux_n1_stream;

  logic        clk;
  logic        rst;
  logic        mode;
  logic [1:0]  s;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready;

  logic        mode3;
  logic [1:0]  s3;
  logic [2:0]  in_valid3;
  logic [47:0] in_data3;
  logic [2:0]  in_ready3;
  logic        out_valid3;
  logic [15:0] out_data3;
  logic [1:0]  out_ch3;
  logic        out_ready3;

  int checks = 0;
  int errors = 0;

  int          mPtr;
  logic        mValid;
  logic [7:0]  mData;
  int          mCh;

  mux_n1_stream #(.N(4), .W(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .s(s),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready)
  );

  mux_n1_stream #(.N(3), .W(16)) dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .s(s3),
    .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3), .out_ready(out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Grant from the rules: fixed select, or first valid channel scanning from ptr modulo 4.
  function automatic int modelGrant(input logic m, input logic [1:0] sel, input logic [3:0] v);
    if (!m) return int'(sel);
    for (int j = 0; j < 4; j++) begin
      if (v[(mPtr + j) % 4]) return (mPtr + j) % 4;
    end
    return -1;
  endfunction

  // One clock cycle: drive inputs, check ready, advance model across the edge, check outputs.
  task automatic applyStimulus(input logic m, input logic [1:0] sel, input logic [3:0] v,
                               input logic [31:0] d, input logic ordy, input logic r);
    int g;
    logic [3:0] er;
    mode = m; s = sel; in_valid = v; in_data = d; out_ready = ordy; rst = r;
    g  = modelGrant(m, sel, v);
    er = 4'b0000;
    if (!r && (!mValid || ordy) && g >= 0) er = 4'(1 << g);
    #1;
    checkOutput("in_ready", 32'(in_ready), 32'(er));
    @(posedge clk);
    #1;
    if (r) begin
      mValid = 1'b0; mData = 8'h00; mCh = 0; mPtr = 0;
    end else if ((!mValid || ordy) && g >= 0 && v[g]) begin
      mValid = 1'b1;
      mData  = d[g*8 +: 8];
      mCh    = g;
      if (m) mPtr = (g + 1) % 4;
    end else if (ordy) begin
      mValid = 1'b0;
    end
    checkOutput("out_valid", 32'(out_valid), 32'(mValid));
    checkOutput("out_data", 32'(out_data), 32'(mData));
    checkOutput("out_ch", 32'(out_ch), 32'(mCh));
  endtask

  logic [7:0] rrSeq [5];
  logic [1:0] wrapSeq [3];

  initial begin
    rrSeq   = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    wrapSeq = '{2'd3, 2'd1, 2'd3};
    mPtr = 0; mValid = 1'b0; mData = 8'h00; mCh = 0;
    mode3 = 1'b0; s3 = 2'd0; in_valid3 = 3'b000; in_data3 = '0; out_ready3 = 1'b1;
    mode = 1'b1; s = 2'd0; in_valid = 4'hF; in_data = 32'h0; out_ready = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset held two cycles with everything valid.
    repeat (2) applyStimulus(1'b1, 2'd0, 4'hF, 32'h44332211, 1'b1, 1'b1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_out_data", 32'(out_data), 32'h0);
    checkOutput("rst_out_ch", 32'(out_ch), 32'h0);

    // Fixed select of channel 2.
    applyStimulus(1'b0, 2'd2, 4'hF, 32'h33A52211, 1'b1, 1'b0);
    checkOutput("fixed_data", 32'(out_data), 32'hA5);
    checkOutput("fixed_ch", 32'(out_ch), 32'h2);
    applyStimulus(1'b0, 2'd2, 4'h0, 32'h33A52211, 1'b1, 1'b0);

    // Round-robin fairness from ptr 0.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 2'd0, 4'hF, 32'h13121110, 1'b1, 1'b0);
      checkOutput("rr_seq", 32'(out_data), 32'(rrSeq[i]));
    end

    // Move ptr to 2 via channel 1, then channels 3 and 1 alternate.
    applyStimulus(1'b1, 2'd0, 4'b0010, 32'h13121110, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'd0, 4'b1010, 32'h13121110, 1'b1, 1'b0);
      checkOutput("rr_wrap", 32'(out_ch), 32'(wrapSeq[i]));
    end

    // Backpressure with a held beat from channel 3.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 2'd0, 4'hF, 32'hDDCCBBAA, 1'b0, 1'b0);
      checkOutput("bp_hold_ch", 32'(out_ch), 32'h3);
      checkOutput("bp_hold_data", 32'(out_data), 32'h13);
    end
    applyStimulus(1'b1, 2'd0, 4'hF, 32'hDDCCBBAA, 1'b1, 1'b0);
    checkOutput("bp_release_valid", 32'(out_valid), 32'h1);
    checkOutput("bp_release_ch", 32'(out_ch), 32'h0);

    // Reset while a beat is held under backpressure discards it.
    applyStimulus(1'b1, 2'd0, 4'hF, 32'hDDCCBBAA, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd0, 4'hF, 32'hDDCCBBAA, 1'b0, 1'b1);
    checkOutput("midrst_valid", 32'(out_valid), 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(1)), 2'($urandom_range(3)), 4'($urandom),
                    $urandom, ($urandom_range(3) != 0), ($urandom_range(59) == 0));
    end
    applyStimulus(1'b0, 2'd0, 4'h0, 32'h0, 1'b1, 1'b0);

    // Three-channel instance: out-of-range select grants nothing.
    mode3 = 1'b0; s3 = 2'd3; in_valid3 = 3'b111; in_data3 = {16'hCCCC, 16'hBBBB, 16'h1234};
    #1;
    checkOutput("n3_s3_ready", 32'(in_ready3), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("n3_s3_valid", 32'(out_valid3), 32'h0);
    s3 = 2'd0;
    #1;
    checkOutput("n3_s0_ready", 32'(in_ready3), 32'h1);
    @(posedge clk);
    #1;
    checkOutput("n3_s0_valid", 32'(out_valid3), 32'h1);
    checkOutput("n3_s0_data", 32'(out_data3), 32'h1234);
    checkOutput("n3_s0_ch", 32'(out_ch3), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
